// File: rtl/pwm_capture.sv
// PWM input decoder: synchronizes an external pulse train and reports its high time and
// rise-to-rise period in i_clk cycles, with a stuck-input timeout.
module pwm_capture #(
  parameter int p_cnt_w       = 16,
  parameter int p_sync_stages = 2
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_en,
  input  logic               i_pwm,
  output logic [p_cnt_w-1:0] o_high,
  output logic [p_cnt_w-1:0] o_period,
  output logic               o_valid,
  output logic               o_timeout,
  output logic               o_level,
  output logic [1:0]         o_dbg_state
);

  // o_valid is a one-cycle strobe with no back-pressure: o_high, o_period and o_timeout
  // are updated on that cycle and hold until the next strobe.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HIGH = 2'd1,
    S_LOW  = 2'd2
  } state_t;

  localparam logic [p_cnt_w-1:0] c_cnt_max = '1;
  localparam logic [p_cnt_w-1:0] c_cnt_one = {{(p_cnt_w-1){1'b0}}, 1'b1};

  state_t               r_state, s_state_n;
  logic [p_sync_stages-1:0] r_sync;
  logic                 r_prev;
  logic                 s_sync, s_rise, s_fall;
  logic [p_cnt_w-1:0]   r_cnt, s_cnt_n, s_cnt_inc;
  logic [p_cnt_w-1:0]   r_high, s_high_n;
  logic [p_cnt_w-1:0]   s_o_high_n, s_o_period_n;
  logic                 s_valid_n, s_timeout_n;

  assign s_sync      = r_sync[p_sync_stages-1];
  assign s_rise      = s_sync & ~r_prev;
  assign s_fall      = ~s_sync & r_prev;
  assign o_level     = s_sync;
  assign o_dbg_state = r_state;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync <= '0;
      r_prev <= 1'b0;
    end else begin
      r_sync <= {r_sync[p_sync_stages-2:0], i_pwm};
      r_prev <= s_sync;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_high    <= '0;
      o_high    <= '0;
      o_period  <= '0;
      o_valid   <= 1'b0;
      o_timeout <= 1'b0;
    end else begin
      r_state   <= s_state_n;
      r_cnt     <= s_cnt_n;
      r_high    <= s_high_n;
      o_high    <= s_o_high_n;
      o_period  <= s_o_period_n;
      o_valid   <= s_valid_n;
      o_timeout <= s_timeout_n;
    end
  end

  always_comb begin
    s_state_n    = r_state;
    s_cnt_n      = r_cnt;
    s_high_n     = r_high;
    s_o_high_n   = o_high;
    s_o_period_n = o_period;
    s_valid_n    = 1'b0;
    s_timeout_n  = o_timeout;
    s_cnt_inc    = (r_cnt == c_cnt_max) ? r_cnt : r_cnt + 1'b1;

    if (!i_en) begin
      s_state_n = S_IDLE;
      s_cnt_n   = '0;
    end else begin
      if (s_rise) s_timeout_n = 1'b0;
      // A rise on the saturation cycle wins, so a period of exactly all-ones still measures.
      if (r_state != S_IDLE && !s_rise && r_cnt == c_cnt_max) begin
        s_timeout_n  = 1'b1;
        s_valid_n    = 1'b1;
        s_o_period_n = c_cnt_max;
        s_o_high_n   = s_sync ? c_cnt_max : '0;
        s_state_n    = S_IDLE;
        s_cnt_n      = '0;
      end else begin
        case (r_state)
          S_IDLE: begin
            s_cnt_n = '0;
            if (s_rise) begin
              s_state_n = S_HIGH;
              s_cnt_n   = c_cnt_one;
            end
          end
          S_HIGH: begin
            s_cnt_n = s_cnt_inc;
            if (s_fall) begin
              s_high_n  = r_cnt;
              s_state_n = S_LOW;
            end
          end
          S_LOW: begin
            if (s_rise) begin
              s_o_period_n = r_cnt;
              s_o_high_n   = r_high;
              s_valid_n    = 1'b1;
              s_cnt_n      = c_cnt_one;
              s_state_n    = S_HIGH;
            end else begin
              s_cnt_n = s_cnt_inc;
            end
          end
          default: begin
            s_state_n = S_IDLE;
            s_cnt_n   = '0;
          end
        endcase
      end
    end
  end

endmodule

// File: doc/pwm_capture.md
Name: pwm_capture

Overview:
PWM input decoder, the receive-side counterpart of the board's LED PWM/blink generators. Samples an external pulse train and measures its high time and period in i_clk cycles. Publishes each completed measurement with a one-cycle valid strobe, and flags a stuck-high or stuck-low input as a timeout. Used for board loopback self-test of LED dimming and for reading externally generated PWM/servo-style signals.

Parameters:
p_cnt_w, 16, width of the period/high-time counters and result outputs.
p_sync_stages, 2, number of synchronizer flops on i_pwm (minimum 2).

Ports:
i_clk  input  1  system clock.
i_rst_n  input  1  reset, asynchronous assert, active-low.
i_en  input  1  capture enable; low forces IDLE.
i_pwm  input  1  asynchronous PWM input pin.
o_high  output  p_cnt_w  last measured high time, in cycles.
o_period  output  p_cnt_w  last measured rise-to-rise period, in cycles.
o_valid  output  1  one-cycle strobe; o_high/o_period updated this cycle.
o_timeout  output  1  input stuck; no rising edge within 2^p_cnt_w-1 cycles.
o_level  output  1  current synchronized input level.

Behaviour:
- Reset: one clock (i_clk); i_rst_n asynchronous, active-low. All flops clear on assertion: sync chain=0, state=IDLE, counters=0; o_high=0, o_period=0, o_valid=0, o_timeout=0, o_level=0.
- Synchronizer: p_sync_stages flops, then one previous-level flop. Rise = sync&~prev; fall = ~sync&prev. o_level = sync.
- Counter r_cnt: set to 1 on a rise, otherwise increments. It saturates at all-ones and never wraps.
- Latched high time: r_high <= r_cnt on a fall.
- For a periodic input of H high and L low cycles (H,L>=1), the block reports o_period=H+L and o_high=H.
- States:
  - IDLE: r_cnt held at 0. A rise moves to HIGH with r_cnt=1, and no o_valid (first period incomplete). A fall is ignored.
  - HIGH: a fall latches r_high and moves to LOW.
  - LOW: a rise sets o_period<=r_cnt, o_high<=r_high, o_valid=1, and r_cnt=1, then moves to HIGH. The output registers change only in the o_valid cycle.
- Timeout: in HIGH or LOW, when r_cnt reaches 2^p_cnt_w-1 with no rise that cycle:
  - o_timeout<=1, o_valid pulses once.
  - o_period<=all-ones; o_high<=all-ones if sync=1 (100% duty), else 0.
  - State moves to IDLE. o_timeout stays 1 until the next rise, where it clears on that same cycle.
  - A rise on the saturation cycle takes priority over the timeout.
- Latency: o_valid asserts p_sync_stages+1 clock edges after the first edge that samples i_pwm high, i.e. 3 cycles at default.
- i_en=0: state forced to IDLE and r_cnt=0 on the next edge, no o_valid. o_high, o_period and o_timeout hold their values. After re-enable, two rises are needed before the next o_valid.
- Reset mid-measurement: any partial count is discarded, and the outputs return to their reset values immediately.
- Minimum measurable pulse is 1 cycle high / 1 cycle low. Shorter glitches may be lost in the synchronizer; this is acceptable.

Test Plan:
- Reset/idle: hold i_rst_n=0, toggle i_pwm -> all outputs 0, no o_valid. Release with i_pwm=0 -> outputs stay 0.
- Steady PWM, H=3, L=5, i_en=1: the first rise gives no strobe; the second and later rises give o_valid every 8 cycles with o_period=8, o_high=3. The first o_valid comes 3 cycles after the second rise is sampled.
- Duty change and extremes:
  - H=1, L=1 -> o_period=2, o_high=1.
  - Switch to H=6, L=2 -> the next strobe reports 8/6 exactly once the first full new period completes.
- Stuck high, p_cnt_w=8: after one rise, hold i_pwm=1 -> a single o_valid, o_timeout=1, o_high=255, o_period=255. A following 4-high/4-low input clears o_timeout at the first rise and reports 8/4 at the second rise.
- Stuck low: same as above with i_pwm=0 -> o_high=0, o_period=255, o_timeout=1.
- Enable/reset mid-period: drop i_en for 2 cycles inside a high phase -> no strobe, outputs hold, the next strobe needs two rises. Assert i_rst_n=0 asynchronously between clock edges -> outputs are 0 before the next i_clk edge.
